// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : PC register and next-PC candidate/select generation with stall,
//            one-entry pending-redirect buffer and post-reset boot cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] choice_0,
  output logic [31:0] choice_1,
  output logic [31:0] choice_2,
  output logic [1:0]  selec,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        redirect_pending
);

  localparam logic [31:0] C_RESET_PC = {RESET_VEC[31:2], 2'b00};
  localparam logic [31:0] C_STEP     = 32'(PC_STEP);
  localparam logic [1:0]  C_SEL_SEQ  = 2'b00;
  localparam logic [1:0]  C_SEL_BR   = 2'b01;
  localparam logic [1:0]  C_SEL_JMP  = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic [31:0] w_imm_off;

  assign w_imm_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign choice_0  = pc_q + C_STEP;
  assign choice_1  = choice_0 + w_imm_off;
  assign choice_2  = {choice_0[31:28], jump_target, 2'b00};

  assign pc               = pc_q;
  assign fetch_valid      = (state_q != S_BOOT);
  assign redirect_pending = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= C_RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0000_0000;
      pend_sel_q <= C_SEL_SEQ;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    pend_sel_d = pend_sel_q;
    selec      = C_SEL_SEQ;

    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (stall) begin
          state_d = S_HOLD;
        end else if (pend_q) begin
          // A buffered redirect is older than anything arriving now.
          pc_d   = pend_pc_q;
          selec  = pend_sel_q;
          pend_d = 1'b0;
        end else if (jump) begin
          pc_d  = choice_2;
          selec = C_SEL_JMP;
        end else if (branch_taken) begin
          pc_d  = choice_1;
          selec = C_SEL_BR;
        end else begin
          pc_d = choice_0;
        end
      end

      S_HOLD: begin
        if (!pend_q && (jump || branch_taken)) begin
          pend_d     = 1'b1;
          pend_pc_d  = jump ? choice_2 : choice_1;
          pend_sel_d = jump ? C_SEL_JMP : C_SEL_BR;
        end
        if (!stall) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed and randomized self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] choice_0, choice_1, choice_2, pc;
  logic [1:0]  selec;
  logic        fetch_valid, redirect_pending;
  logic [31:0] b_choice_0, b_choice_1, b_choice_2, b_pc;
  logic [1:0]  b_selec;
  logic        b_fetch_valid, b_redirect_pending;

  int n_checks = 0;
  int n_errors = 0;

  localparam int C_BOOT = 0;
  localparam int C_RUN  = 1;
  localparam int C_HOLD = 2;

  int          m_mode;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [1:0]  m_pend_sel;

  pc_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .imm16(imm16), .jump(jump), .jump_target(jump_target),
    .choice_0(choice_0), .choice_1(choice_1), .choice_2(choice_2),
    .selec(selec), .pc(pc), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending)
  );

  // Unaligned reset vector: low bits must be dropped.
  pc_sequencer #(.RESET_VEC(32'h9000_0012)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .imm16(imm16), .jump(jump), .jump_target(jump_target),
    .choice_0(b_choice_0), .choice_1(b_choice_1), .choice_2(b_choice_2),
    .selec(b_selec), .pc(b_pc), .fetch_valid(b_fetch_valid),
    .redirect_pending(b_redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode     = C_BOOT;
    m_pc       = 32'h0;
    m_pend     = 1'b0;
    m_pend_pc  = 32'h0;
    m_pend_sel = 2'b00;
  endtask

  // Called at a falling edge; drives inputs, checks outputs against the
  // model, lets one rising edge pass, advances the model, returns at next fall.
  task automatic run_cycle(input logic s, input logic b, input logic [15:0] im,
                           input logic j, input logic [25:0] jt);
    logic [31:0] c0, c1, c2, off, nxt;
    logic [1:0]  esel;
    stall = s; branch_taken = b; imm16 = im; jump = j; jump_target = jt;
    #1;
    off = {{16{im[15]}}, im};
    c0  = m_pc + 32'd4;
    c1  = c0 + off * 32'd4;
    c2  = {c0[31:28], jt, 2'b00};
    esel = 2'b00;
    nxt  = m_pc;
    if (m_mode == C_RUN && !s) begin
      if (m_pend)  begin esel = m_pend_sel; nxt = m_pend_pc; end
      else if (j)  begin esel = 2'd2;       nxt = c2;        end
      else if (b)  begin esel = 2'd1;       nxt = c1;        end
      else         begin                    nxt = c0;        end
    end
    check_eq("pc", pc, m_pc);
    check_eq("fetch_valid", 32'(fetch_valid), 32'(m_mode != C_BOOT));
    check_eq("redirect_pending", 32'(redirect_pending), 32'(m_pend));
    check_eq("choice_0", choice_0, c0);
    check_eq("choice_1", choice_1, c1);
    check_eq("choice_2", choice_2, c2);
    check_eq("selec", 32'(selec), 32'(esel));
    @(posedge clk);
    case (m_mode)
      C_BOOT: m_mode = C_RUN;
      C_RUN: begin
        if (s) m_mode = C_HOLD;
        else begin
          if (m_pend) m_pend = 1'b0;
          m_pc = nxt;
        end
      end
      default: begin
        if (!m_pend && (j || b)) begin
          m_pend     = 1'b1;
          m_pend_pc  = j ? c2 : c1;
          m_pend_sel = j ? 2'd2 : 2'd1;
        end
        if (!s) m_mode = C_RUN;
      end
    endcase
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; imm16 = 16'h0;
    jump = 1'b0; jump_target = 26'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_fv", 32'(fetch_valid), 32'h0);
    check_eq("rst_rp", 32'(redirect_pending), 32'h0);
    check_eq("rst_selec", 32'(selec), 32'h0);
    check_eq("rst_pc_hi", b_pc, 32'h9000_0010);
    rst_n = 1'b1;

    // Boot cycle then sequential 0, 4, 8.
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("boot_pc0", pc, 32'h0);
    check_eq("boot_fv", 32'(fetch_valid), 32'h1);
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("seq_pc4", pc, 32'h4);
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("seq_pc8", pc, 32'h8);

    // Branch to 0x100, then branch-to-self with imm16 = -1.
    run_cycle(0, 1, 16'h003D, 0, 26'h0);
    check_eq("br_pc100", pc, 32'h100);
    branch_taken = 1'b1; imm16 = 16'hFFFF; #1;
    check_eq("br_choice1", choice_1, 32'h100);
    check_eq("br_selec", 32'(selec), 32'h1);
    run_cycle(0, 1, 16'hFFFF, 0, 26'h0);
    check_eq("br_self", pc, 32'h100);

    // Wrap-around at the top of the address space.
    run_cycle(0, 0, 16'h0, 1, 26'h0);
    run_cycle(0, 1, 16'hFFFE, 0, 26'h0);
    check_eq("wrap_top", pc, 32'hFFFF_FFFC);
    branch_taken = 1'b0; jump = 1'b0; #1;
    check_eq("wrap_choice0", choice_0, 32'h0);
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("wrap_pc0", pc, 32'h0);

    // Stall with buffered jump; later branch must be ignored.
    run_cycle(1, 0, 16'h0, 0, 26'h0);
    run_cycle(1, 0, 16'h0, 1, 26'h10);
    check_eq("stall_rp", 32'(redirect_pending), 32'h1);
    run_cycle(1, 1, 16'h0100, 0, 26'h0);
    check_eq("stall_pc", pc, 32'h0);
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("release_hold_pc", pc, 32'h0);
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; #1;
    check_eq("release_selec", 32'(selec), 32'h2);
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("release_pc", pc, 32'h40);
    check_eq("release_rp", 32'(redirect_pending), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
                16'($urandom), ($urandom_range(0, 99) < 15), 26'($urandom));
    end

    // Fill the buffer in HOLD, then reset asynchronously mid-cycle.
    run_cycle(1, 0, 16'h0, 0, 26'h0);
    run_cycle(1, 0, 16'h0, 1, 26'h123);
    check_eq("hold_full_rp", 32'(redirect_pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_pc", pc, 32'h0);
    check_eq("async_rst_rp", 32'(redirect_pending), 32'h0);
    check_eq("async_rst_fv", 32'(fetch_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(0, 0, 16'h0, 0, 26'h0);
    check_eq("hi_boot_pc", b_pc, 32'h9000_0010);

    // Jump beats branch, observed on the high-vector instance.
    stall = 1'b0; branch_taken = 1'b1; imm16 = 16'h0005; jump = 1'b1; jump_target = 26'h40; #1;
    check_eq("jb_selec", 32'(b_selec), 32'h2);
    run_cycle(0, 1, 16'h0005, 1, 26'h40);
    check_eq("jb_pc", b_pc, 32'h9000_0100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
